// File: rtl/dram_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : dram_arbiter_if
// Description : Bundle of every handshake/bus signal around dram_arbiter:
//               the two memory clients (port 0 = I-cache line fill, read
//               only; port 1 = data side, read/write) and the DRAM
//               controller user port.
//               modport master : arbiter view (masters the DRAM user port,
//                                serves both clients)
//               modport slave  : environment view (clients + controller)
// Revision    : 1.0  initial release
//============================================================================
interface dram_arbiter_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
);

  // Port 0: instruction-cache line fill (read only)
  logic                  m0_ren;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic                  m0_ready;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_rvalid;

  // Port 1: data side (read/write)
  logic                  m1_ren;
  logic                  m1_wen;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic [MASK_WIDTH-1:0] m1_wmask;
  logic                  m1_ready;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_rvalid;

  // DRAM controller user port
  logic                  dram_ren;
  logic                  dram_wen;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic [DATA_WIDTH-1:0] dram_wdata;
  logic [MASK_WIDTH-1:0] dram_wmask;
  logic                  dram_busy;
  logic                  dram_init_calib_complete;
  logic [DATA_WIDTH-1:0] dram_rdata;
  logic                  dram_rdata_valid;

  modport master (
    input  m0_ren, m0_addr,
    output m0_ready, m0_rdata, m0_rvalid,
    input  m1_ren, m1_wen, m1_addr, m1_wdata, m1_wmask,
    output m1_ready, m1_rdata, m1_rvalid,
    output dram_ren, dram_wen, dram_addr, dram_wdata, dram_wmask,
    input  dram_busy, dram_init_calib_complete, dram_rdata, dram_rdata_valid
  );

  modport slave (
    output m0_ren, m0_addr,
    input  m0_ready, m0_rdata, m0_rvalid,
    output m1_ren, m1_wen, m1_addr, m1_wdata, m1_wmask,
    input  m1_ready, m1_rdata, m1_rvalid,
    input  dram_ren, dram_wen, dram_addr, dram_wdata, dram_wmask,
    output dram_busy, dram_init_calib_complete, dram_rdata, dram_rdata_valid
  );

endinterface
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
//============================================================================
// Module      : dram_arbiter
// Description : Two-port arbiter in front of the single DRAM user port.
//               Serialises 128-bit line commands from the I-cache fill
//               client (port 0, read only) and the data client (port 1,
//               read/write), honours controller busy/calibration status and
//               routes returning read data to the owning client. At most one
//               DRAM read is outstanding.
// Ports       : clock, reset       - DRAM user clock, synchronous active-high
//               bus (master)       - client requests/ready/rdata/rvalid and
//                                    DRAM ren/wen/addr/wdata/wmask/busy/
//                                    calib/rdata/rdata_valid
// Config      : DRAM_ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration
//               DRAM_ARB_ROUND_ROBIN_EN undefined -> fixed priority, port 1
// Revision    : 1.0  initial release
//============================================================================
module dram_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
) (
  input wire             clock,
  input wire             reset,
  dram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_owner;      // 0 = port 0, 1 = port 1
  logic                  r_dram_ren;
  logic                  r_dram_wen;
  logic [ADDR_WIDTH-1:0] r_dram_addr;
  logic [DATA_WIDTH-1:0] r_dram_wdata;
  logic [MASK_WIDTH-1:0] r_dram_wmask;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;

  logic                  w_m1_req;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_sel_m1;
  logic                  w_m0_ready;
  logic                  w_m1_ready;

  assign w_m1_req = bus.m1_ren | bus.m1_wen;
  assign w_grant  = (r_state == IDLE) & bus.dram_init_calib_complete &
                    (bus.m0_ren | w_m1_req);
  assign w_accept = (r_state == ISSUE) & ~bus.dram_busy;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  // Remembers which port won the most recent grant. Resetting it to
  // "port 1 last" makes port 0 win the first contended grant.
  logic r_last_m1;

  always_comb begin
    w_sel_m1 = w_m1_req;
    if (bus.m0_ren && w_m1_req) begin
      w_sel_m1 = ~r_last_m1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_m1 <= 1'b1;
    end else if (w_grant) begin
      r_last_m1 <= w_sel_m1;
    end
  end
`else
  // Fixed priority: data side wins whenever it requests.
  assign w_sel_m1 = w_m1_req;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the combinational ready pulses
  always_comb begin
    w_state_nxt = r_state;
    w_m0_ready  = 1'b0;
    w_m1_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.dram_busy) begin
          w_m0_ready  = ~r_owner;
          w_m1_ready  = r_owner;
          // The issued command itself tells us whether data will return.
          w_state_nxt = r_dram_ren ? RDWAIT : IDLE;
        end
      end
      RDWAIT: begin
        if (bus.dram_rdata_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, owner tag and read-data return path
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_dram_ren   <= 1'b0;
      r_dram_wen   <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_wdata <= '0;
      r_dram_wmask <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;

      if (w_grant) begin
        r_owner     <= w_sel_m1;
        r_dram_addr <= w_sel_m1 ? bus.m1_addr : bus.m0_addr;
        // On port 1 a simultaneous read+write is illegal; the write wins.
        r_dram_wen  <= w_sel_m1 & bus.m1_wen;
        r_dram_ren  <= ~w_sel_m1 | ~bus.m1_wen;
        if (w_sel_m1 && bus.m1_wen) begin
          r_dram_wdata <= bus.m1_wdata;
          r_dram_wmask <= bus.m1_wmask;
        end
      end else if (w_accept) begin
        r_dram_ren <= 1'b0;
        r_dram_wen <= 1'b0;
      end

      // Data returning outside RDWAIT (e.g. after a mid-read reset) is dropped.
      if ((r_state == RDWAIT) && bus.dram_rdata_valid) begin
        if (r_owner) begin
          r_m1_rdata  <= bus.dram_rdata;
          r_m1_rvalid <= 1'b1;
        end else begin
          r_m0_rdata  <= bus.dram_rdata;
          r_m0_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.m0_ready   = w_m0_ready;
  assign bus.m1_ready   = w_m1_ready;
  assign bus.m0_rdata   = r_m0_rdata;
  assign bus.m1_rdata   = r_m1_rdata;
  assign bus.m0_rvalid  = r_m0_rvalid;
  assign bus.m1_rvalid  = r_m1_rvalid;
  assign bus.dram_ren   = r_dram_ren;
  assign bus.dram_wen   = r_dram_wen;
  assign bus.dram_addr  = r_dram_addr;
  assign bus.dram_wdata = r_dram_wdata;
  assign bus.dram_wmask = r_dram_wmask;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench for dram_arbiter. Each scenario task
//               pushes expected DRAM commands / read returns into queues as
//               it drives stimulus and pops them when the DUT responds.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0  initial release
//============================================================================
module tb_dram_arbiter;

  localparam int ADDR_WIDTH = 27;
  localparam int DATA_WIDTH = 128;
  localparam int MASK_WIDTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  dram_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                    .MASK_WIDTH(MASK_WIDTH)) bus ();

  dram_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                 .MASK_WIDTH(MASK_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic                  ren;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
    logic                  port;
  } cmd_t;

  typedef struct {
    logic                  port;
    logic [DATA_WIDTH-1:0] data;
  } rd_t;

  cmd_t exp_cmd_q[$];
  rd_t  exp_rd_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic cmd_t mk_cmd(input logic ren, input logic wen,
                                  input logic [ADDR_WIDTH-1:0] addr,
                                  input logic [DATA_WIDTH-1:0] wdata,
                                  input logic [MASK_WIDTH-1:0] wmask,
                                  input logic port);
    cmd_t c;
    c.ren = ren; c.wen = wen; c.addr = addr;
    c.wdata = wdata; c.wmask = wmask; c.port = port;
    return c;
  endfunction

  function automatic rd_t mk_rd(input logic port, input logic [DATA_WIDTH-1:0] data);
    rd_t r;
    r.port = port; r.data = data;
    return r;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.m0_ren = 1'b0; bus.m0_addr = '0;
    bus.m1_ren = 1'b0; bus.m1_wen = 1'b0; bus.m1_addr = '0;
    bus.m1_wdata = '0; bus.m1_wmask = '0;
    bus.dram_busy = 1'b0; bus.dram_rdata = '0; bus.dram_rdata_valid = 1'b0;
  endtask

  // Advance until a DRAM command appears, at most budget cycles.
  task automatic wait_cmd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.dram_ren === 1'b1 || bus.dram_wen === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present one read-data beat from the controller for a single cycle.
  task automatic dram_return(input logic [DATA_WIDTH-1:0] data);
    bus.dram_rdata = data;
    bus.dram_rdata_valid = 1'b1;
    tick();
    bus.dram_rdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.dram_init_calib_complete = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.dram_ren, bus.dram_wen} !== 2'b00) begin
      errors++; $display("FAIL reset_cmd: got ren/wen=%b exp 00", {bus.dram_ren, bus.dram_wen});
    end
    checks++;
    if (bus.dram_addr !== '0 || bus.dram_wdata !== '0 || bus.dram_wmask !== '0) begin
      errors++; $display("FAIL reset_payload: got addr=%h wdata=%h wmask=%h exp all 0",
                         bus.dram_addr, bus.dram_wdata, bus.dram_wmask);
    end
    checks++;
    if (bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got m0=%h m1=%h exp 0", bus.m0_rdata, bus.m1_rdata);
    end
    checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_ready, bus.m1_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got rvalid/ready=%b exp 0000",
                         {bus.m0_rvalid, bus.m1_rvalid, bus.m0_ready, bus.m1_ready});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.dram_ren, bus.dram_wen} !== 2'b00) begin
      errors++; $display("FAIL reset_idle_no_req: got ren/wen=%b exp 00", {bus.dram_ren, bus.dram_wen});
    end
  endtask

  task automatic test_calib_gate();
    cmd_t c;
    rd_t  r;
    bus.dram_init_calib_complete = 1'b0;
    bus.m0_addr = 27'h0000A5C;
    bus.m0_ren  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.dram_ren !== 1'b0 || bus.dram_wen !== 1'b0 || bus.m0_ready !== 1'b0) begin
        errors++; $display("FAIL calib_gate cycle %0d: got ren=%b wen=%b ready=%b exp 0", i,
                           bus.dram_ren, bus.dram_wen, bus.m0_ready);
      end
    end
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 27'h0000A5C, '0, '0, 1'b0));
    bus.dram_init_calib_complete = 1'b1;
    tick();
    c = exp_cmd_q.pop_front();
    checks++;
    if (bus.dram_ren !== c.ren || bus.dram_wen !== c.wen || bus.dram_addr !== c.addr) begin
      errors++; $display("FAIL calib_release_cmd: got ren=%b wen=%b addr=%h exp ren=%b wen=%b addr=%h",
                         bus.dram_ren, bus.dram_wen, bus.dram_addr, c.ren, c.wen, c.addr);
    end
    checks++;
    if (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0) begin
      errors++; $display("FAIL calib_ready: got m0=%b m1=%b exp 1 0", bus.m0_ready, bus.m1_ready);
    end
    tick();
    bus.m0_ren = 1'b0;
    exp_rd_q.push_back(mk_rd(1'b0, 128'h11112222_33334444_55556666_77778888));
    dram_return(128'h11112222_33334444_55556666_77778888);
    r = exp_rd_q.pop_front();
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== r.data) begin
      errors++; $display("FAIL calib_read_return: got rvalid=%b data=%h exp 1 %h",
                         bus.m0_rvalid, bus.m0_rdata, r.data);
    end
  endtask

  task automatic test_single_read();
    cmd_t c;
    rd_t  r;
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 27'h0000100, '0, '0, 1'b0));
    bus.m0_addr = 27'h0000100;
    bus.m0_ren  = 1'b1;
    tick();
    c = exp_cmd_q.pop_front();
    checks++;
    if (bus.dram_ren !== c.ren || bus.dram_wen !== c.wen || bus.dram_addr !== c.addr ||
        bus.m0_ready !== 1'b1) begin
      errors++; $display("FAIL single_read_cmd: got ren=%b wen=%b addr=%h ready=%b exp 1 0 %h 1",
                         bus.dram_ren, bus.dram_wen, bus.dram_addr, bus.m0_ready, c.addr);
    end
    tick();
    bus.m0_ren = 1'b0;
    checks++;
    if (bus.dram_ren !== 1'b0 || bus.m0_ready !== 1'b0) begin
      errors++; $display("FAIL single_read_drop: got ren=%b ready=%b exp 0 0", bus.dram_ren, bus.m0_ready);
    end
    repeat (3) tick();
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_read_early_rvalid: got m0=%b m1=%b exp 0 0", bus.m0_rvalid, bus.m1_rvalid);
    end
    exp_rd_q.push_back(mk_rd(1'b0, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01));
    dram_return(128'hDEADBEEF_CAFEF00D_12345678_9ABCDE01);
    r = exp_rd_q.pop_front();
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== r.data || bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_read_return: got m0_rvalid=%b data=%h m1_rvalid=%b exp 1 %h 0",
                         bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, r.data);
    end
    tick();
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== r.data || bus.m1_rdata !== '0) begin
      errors++; $display("FAIL single_read_hold: got rvalid=%b m0_rdata=%h m1_rdata=%h exp 0 %h 0",
                         bus.m0_rvalid, bus.m0_rdata, bus.m1_rdata, r.data);
    end
  endtask

  task automatic test_busy_stall();
    cmd_t c;
    int   wen_cycles;
    exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 27'h1234567,
                               128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'h00F0, 1'b1));
    bus.dram_busy = 1'b1;
    bus.m1_addr   = 27'h1234567;
    bus.m1_wdata  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    bus.m1_wmask  = 16'h00F0;
    bus.m1_wen    = 1'b1;
    c = exp_cmd_q.pop_front();
    wen_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.dram_wen === 1'b1) wen_cycles++;
      checks++;
      if (bus.dram_wen !== 1'b1 || bus.dram_ren !== 1'b0 || bus.dram_addr !== c.addr ||
          bus.dram_wdata !== c.wdata || bus.dram_wmask !== c.wmask || bus.m1_ready !== 1'b0) begin
        errors++; $display("FAIL busy_stall cycle %0d: got wen=%b ren=%b addr=%h wdata=%h wmask=%h ready=%b exp 1 0 %h %h %h 0",
                           i, bus.dram_wen, bus.dram_ren, bus.dram_addr, bus.dram_wdata, bus.dram_wmask,
                           bus.m1_ready, c.addr, c.wdata, c.wmask);
      end
    end
    bus.dram_busy = 1'b0;
    #1;
    if (bus.dram_wen === 1'b1) wen_cycles++;
    checks++;
    if (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0 || bus.dram_wdata !== c.wdata) begin
      errors++; $display("FAIL busy_accept: got m1_ready=%b m0_ready=%b wdata=%h exp 1 0 %h",
                         bus.m1_ready, bus.m0_ready, bus.dram_wdata, c.wdata);
    end
    tick();
    bus.m1_wen = 1'b0;
    checks++;
    if (wen_cycles != 6 || bus.dram_wen !== 1'b0 || bus.m1_ready !== 1'b0) begin
      errors++; $display("FAIL busy_wen_length: got %0d cycles wen_now=%b ready=%b exp 6 0 0",
                         wen_cycles, bus.dram_wen, bus.m1_ready);
    end
  endtask

  task automatic test_illegal();
    cmd_t c;
    exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 27'h0ABCDEF,
                               128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 16'h8001, 1'b1));
    bus.m1_addr  = 27'h0ABCDEF;
    bus.m1_wdata = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    bus.m1_wmask = 16'h8001;
    bus.m1_ren   = 1'b1;
    bus.m1_wen   = 1'b1;
    tick();
    c = exp_cmd_q.pop_front();
    checks++;
    if (bus.dram_wen !== c.wen || bus.dram_ren !== c.ren || bus.dram_addr !== c.addr ||
        bus.dram_wmask !== c.wmask || bus.m1_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_cmd: got wen=%b ren=%b addr=%h wmask=%h ready=%b exp 1 0 %h %h 1",
                         bus.dram_wen, bus.dram_ren, bus.dram_addr, bus.dram_wmask, bus.m1_ready,
                         c.addr, c.wmask);
    end
    tick();
    bus.m1_ren = 1'b0;
    bus.m1_wen = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.dram_ren !== 1'b0 || bus.dram_wen !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL illegal_after: got ren=%b wen=%b m1_rvalid=%b exp 0 0 0",
                         bus.dram_ren, bus.dram_wen, bus.m1_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c;
    for (int i = 0; i < 3; i++) begin
      exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 27'(32'h10 + i),
                                 {4{32'hC0DE0000 + 32'(i)}}, 16'(16'h0101 << i), 1'b1));
    end
    bus.m1_addr  = 27'h10;
    bus.m1_wdata = {4{32'hC0DE0000}};
    bus.m1_wmask = 16'h0101;
    bus.m1_wen   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      c = exp_cmd_q.pop_front();
      checks++;
      if (bus.dram_wen !== 1'b1 || bus.dram_addr !== c.addr || bus.dram_wdata !== c.wdata ||
          bus.dram_wmask !== c.wmask || bus.m1_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_write %0d: got wen=%b addr=%h wdata=%h wmask=%h ready=%b exp 1 %h %h %h 1",
                           i, bus.dram_wen, bus.dram_addr, bus.dram_wdata, bus.dram_wmask, bus.m1_ready,
                           c.addr, c.wdata, c.wmask);
      end
      tick();
      checks++;
      if (bus.dram_wen !== 1'b0) begin
        errors++; $display("FAIL b2b_gap %0d: got wen=%b exp 0", i, bus.dram_wen);
      end
      if (i < 2) begin
        bus.m1_addr  = 27'(32'h10 + i + 1);
        bus.m1_wdata = {4{32'hC0DE0000 + 32'(i + 1)}};
        bus.m1_wmask = 16'(16'h0101 << (i + 1));
      end else begin
        bus.m1_wen = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic exp_port [5];
    cmd_t c;
    rd_t  r;
    bit   ok;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_port = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, exp_port[k] ? 27'h3000 : 27'h2000, '0, '0, exp_port[k]));
    end
    bus.m0_addr = 27'h2000;
    bus.m1_addr = 27'h3000;
    bus.m0_ren  = 1'b1;
    bus.m1_ren  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus.m1_ren = 1'b0;
      wait_cmd(10, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL contention_timeout grant %0d: got no command exp command", k);
        break;
      end
      c = exp_cmd_q.pop_front();
      checks++;
      if (bus.m1_ready !== c.port || bus.m0_ready !== ~c.port || bus.dram_ren !== 1'b1 ||
          bus.dram_addr !== c.addr) begin
        errors++; $display("FAIL contention_grant %0d: got m0_ready=%b m1_ready=%b ren=%b addr=%h exp port %0d addr %h",
                           k, bus.m0_ready, bus.m1_ready, bus.dram_ren, bus.dram_addr, c.port, c.addr);
      end
      tick();
      if (k == 4) bus.m0_ren = 1'b0;
      exp_rd_q.push_back(mk_rd(c.port, {4{32'hBEEF0000 + 32'(k)}}));
      dram_return({4{32'hBEEF0000 + 32'(k)}});
      r = exp_rd_q.pop_front();
      checks++;
      if ((r.port  && (bus.m1_rvalid !== 1'b1 || bus.m0_rvalid !== 1'b0 || bus.m1_rdata !== r.data)) ||
          (!r.port && (bus.m0_rvalid !== 1'b1 || bus.m1_rvalid !== 1'b0 || bus.m0_rdata !== r.data))) begin
        errors++; $display("FAIL contention_return %0d: got m0_rvalid=%b m1_rvalid=%b m0=%h m1=%h exp port %0d data %h",
                           k, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, r.port, r.data);
      end
    end
    bus.m0_ren = 1'b0;
    bus.m1_ren = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    cmd_t c;
    rd_t  r;
    bus.m0_addr = 27'h4444;
    bus.m0_ren  = 1'b1;
    tick();
    checks++;
    if (bus.dram_ren !== 1'b1 || bus.m0_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_issue: got ren=%b ready=%b exp 1 1", bus.dram_ren, bus.m0_ready);
    end
    tick();
    bus.m0_ren = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    dram_return(128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0 || bus.m0_rdata !== '0) begin
        errors++; $display("FAIL midreset_discard %0d: got m0_rvalid=%b m1_rvalid=%b m0_rdata=%h exp 0 0 0",
                           i, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata);
      end
      tick();
    end
    exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 27'h5555, '0, '0, 1'b0));
    bus.m0_addr = 27'h5555;
    bus.m0_ren  = 1'b1;
    tick();
    c = exp_cmd_q.pop_front();
    checks++;
    if (bus.dram_ren !== c.ren || bus.dram_addr !== c.addr || bus.m0_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_next_cmd: got ren=%b addr=%h ready=%b exp 1 %h 1",
                         bus.dram_ren, bus.dram_addr, bus.m0_ready, c.addr);
    end
    tick();
    bus.m0_ren = 1'b0;
    exp_rd_q.push_back(mk_rd(1'b0, 128'h600D600D_00000000_11111111_22222222));
    dram_return(128'h600D600D_00000000_11111111_22222222);
    r = exp_rd_q.pop_front();
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== r.data || bus.m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL midreset_next_return: got rvalid=%b data=%h m1_rvalid=%b exp 1 %h 0",
                         bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, r.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running exp finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    bus.dram_init_calib_complete = 1'b0;
    test_reset();
    test_calib_gate();
    test_single_read();
    test_busy_stall();
    test_illegal();
    test_back_to_back();
    test_contention();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
